ctech_lib_sync_filter: RTL

//  Generalised multi-stage synchroniser for async level inputs (straps, fuses, pad status, cross-domain flags).
//  Per channel: STAGES-deep sync chain, optional glitch filter, registered rise/fall pulses.

---
 rtl/ctech_lib_sync_pkg.sv | 14 +
 rtl/ctech_lib_sync_glitch_filter.sv | 69 ++++++
 rtl/ctech_lib_sync_filter.sv | 66 ++++++
 3 files changed

// File: rtl/ctech_lib_sync_pkg.sv
// Shared constants and helpers for the multi-stage synchroniser / glitch filter.
package ctech_lib_sync_pkg;

   localparam int SYNC_MIN_STAGES = 2;
   localparam int SYNC_MIN_FILTER = 1;

   // Counter width able to hold 0..f, never narrower than one bit.
   function automatic int sync_cnt_w(input int f);
      int w;
      w = $clog2(f + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ctech_lib_sync_glitch_filter.sv
// One-channel output stage: optional stability filter plus registered rise/fall pulses.
// Filter present only when CTECH_LIB_SYNC_GLITCH_FILTER_EN is defined; otherwise o follows sq.
module ctech_lib_sync_glitch_filter #(
`ifdef CTECH_LIB_SYNC_GLITCH_FILTER_EN
   parameter int   FILTER_CYCLES = 4,
`endif
   parameter logic RST_VAL       = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sq,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_level;
   logic r_rise;
   logic r_fall;
   logic w_level_next;

`ifdef CTECH_LIB_SYNC_GLITCH_FILTER_EN
   import ctech_lib_sync_pkg::*;

   localparam int            CW = sync_cnt_w(FILTER_CYCLES);
   localparam logic [CW-1:0] TC = CW'(FILTER_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_next;

   // Any agreement between sq and o drops the run count, so glitches never accumulate.
   always_comb begin
      w_cnt_next   = '0;
      w_level_next = r_level;
      if (i_sq != r_level) begin
         if (r_cnt == TC) begin
            w_level_next = i_sq;
         end else begin
            w_cnt_next = r_cnt + CW'(1);
         end
      end
   end
`else
   assign w_level_next = i_sq;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_level <= RST_VAL;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
`ifdef CTECH_LIB_SYNC_GLITCH_FILTER_EN
         r_cnt   <= '0;
`endif
      end else begin
         r_level <= w_level_next;
         r_rise  <= ~r_level & w_level_next;
         r_fall  <= r_level & ~w_level_next;
`ifdef CTECH_LIB_SYNC_GLITCH_FILTER_EN
         r_cnt   <= w_cnt_next;
`endif
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/ctech_lib_sync_filter.sv
// Multi-stage synchroniser for asynchronous level inputs with per-channel edge pulses.
// Optional glitch filter enabled by defining CTECH_LIB_SYNC_GLITCH_FILTER_EN.
module ctech_lib_sync_filter
   import ctech_lib_sync_pkg::*;
#(
   parameter int               WIDTH         = 1,
   parameter int               STAGES        = 2,
   parameter int               FILTER_CYCLES = 4,
   parameter logic [WIDTH-1:0] RST_VAL       = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] o,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
      $error("ctech_lib_sync_filter: STAGES=%0d, needs at least %0d", STAGES, SYNC_MIN_STAGES);
   end

`ifdef CTECH_LIB_SYNC_GLITCH_FILTER_EN
   if (FILTER_CYCLES < SYNC_MIN_FILTER) begin : g_bad_filter
      $error("ctech_lib_sync_filter: FILTER_CYCLES=%0d, needs at least %0d", FILTER_CYCLES, SYNC_MIN_FILTER);
   end
`else
   // Harmless here since the filter is compiled out, but likely a misconfiguration.
   if (FILTER_CYCLES < SYNC_MIN_FILTER) begin : g_odd_filter
      $warning("ctech_lib_sync_filter: FILTER_CYCLES=%0d ignored, filter compiled out", FILTER_CYCLES);
   end
`endif

   logic [STAGES-1:0][WIDTH-1:0] r_sync;
   logic [WIDTH-1:0]             w_sq;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= {STAGES{RST_VAL}};
      end else begin
         r_sync[0] <= d;
         for (int k = 1; k < STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
         end
      end
   end

   assign w_sq = r_sync[STAGES-1];

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      ctech_lib_sync_glitch_filter #(
`ifdef CTECH_LIB_SYNC_GLITCH_FILTER_EN
         .FILTER_CYCLES (FILTER_CYCLES),
`endif
         .RST_VAL       (RST_VAL[g])
      ) u_filter (
         .i_clk   (clk),
         .i_rst   (rst),
         .i_sq    (w_sq[g]),
         .o_level (o[g]),
         .o_rise  (rise[g]),
         .o_fall  (fall[g])
      );
   end

endmodule
